// File: rtl/prime_ctrl_pkg.sv
// prime_ctrl_pkg: shared state encoding and datapath width for the prime tester controller and datapath
package prime_ctrl_pkg;
  localparam int DW = 16;
  typedef enum logic [3:0] {
    IDLE, CLR, LOAD, INIT, CHKDIV, REMINIT, REMLOOP, CHKREM, NOTP, DONE
  } state_t;
endpackage

// File: rtl/prime_ctrl.sv
// prime_ctrl: trial-division primality FSM; takes start + datapath status, drives datapath clear/load enables/selects, busy and done
module prime_ctrl
  import prime_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic n_lt2,
  input  logic div_gt_half,
  input  logic rem_lt_div,
  input  logic rem_zero,
  output logic dprst,
  output logic nc,
  output logic divc,
  output logic tmp1c,
  output logic tmp2c,
  output logic resc,
  output logic div_sel,
  output logic tmp1_sel,
  output logic busy,
  output logic done
);
  state_t state, nxt;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLR : IDLE;
      CLR:     nxt = LOAD;
      LOAD:    nxt = INIT;
      INIT:    nxt = n_lt2 ? NOTP : CHKDIV;
      CHKDIV:  nxt = div_gt_half ? DONE : REMINIT;
      REMINIT: nxt = REMLOOP;
      REMLOOP: nxt = rem_lt_div ? CHKREM : REMLOOP;
      CHKREM:  nxt = rem_zero ? NOTP : CHKDIV;
      NOTP:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    dprst    = state == CLR;
    nc       = state == LOAD;
    tmp2c    = state == INIT;
    div_sel  = state == CHKREM && !rem_zero;
    divc     = tmp2c || div_sel;
    tmp1_sel = state == REMLOOP && !rem_lt_div;
    tmp1c    = state == REMINIT || tmp1_sel;
    resc     = state == NOTP;
    done     = state == DONE;
    busy     = state != IDLE;
  end
endmodule

// File: tb/tb_prime_ctrl.sv
// tb_prime_ctrl: randomized self-checking bench with datapath model and per-cycle expected output trace
module tb_prime_ctrl;
  import prime_ctrl_pkg::*;
  localparam logic [9:0] DPRST = 10'h200, NC = 10'h100, DIVC = 10'h080, TMP1C = 10'h040,
    TMP2C = 10'h020, RESC = 10'h010, DSEL = 10'h008, TSEL = 10'h004, DN = 10'h002, B = 10'h001;
  logic clk = 0, rst = 1, start = 0;
  logic n_lt2, div_gt_half, rem_lt_div, rem_zero;
  logic dprst, nc, divc, tmp1c, tmp2c, resc, div_sel, tmp1_sel, busy, done;
  logic [DW-1:0] n_in = 0, n = 0, dv = 0, tmp1 = 0, tmp2 = 0;
  logic res = 1;
  logic chk_en = 0;
  logic [9:0] tr[$], q[$];
  int checks = 0, failures = 0;

  prime_ctrl dut (.clk(clk), .rst(rst), .start(start), .n_lt2(n_lt2), .div_gt_half(div_gt_half),
    .rem_lt_div(rem_lt_div), .rem_zero(rem_zero), .dprst(dprst), .nc(nc), .divc(divc), .tmp1c(tmp1c),
    .tmp2c(tmp2c), .resc(resc), .div_sel(div_sel), .tmp1_sel(tmp1_sel), .busy(busy), .done(done));

  always #5 clk = ~clk;

  assign n_lt2 = n < 2;
  assign div_gt_half = dv > tmp2;
  assign rem_lt_div = tmp1 < dv;
  assign rem_zero = tmp1 == 0;

  always @(posedge clk) begin
    if (dprst) begin
      n <= 0; dv <= 0; tmp1 <= 0; tmp2 <= 0; res <= 1;
    end else begin
      if (nc) n <= n_in;
      if (tmp2c) tmp2 <= n >> 1;
      if (divc) dv <= div_sel ? dv + 1 : 2;
      if (tmp1c) tmp1 <= tmp1_sel ? tmp1 - dv : n;
      if (resc) res <= 0;
    end
  end

  function automatic bit is_prime(input int x);
    if (x < 2) return 0;
    for (int d = 2; d < x; d++) if (x % d == 0) return 0;
    return 1;
  endfunction

  function automatic void gen(input int x, input int maxlen);
    int d, r;
    tr.delete();
    tr.push_back(B | DPRST);
    tr.push_back(B | NC);
    tr.push_back(B | TMP2C | DIVC);
    if (x < 2) begin
      tr.push_back(B | RESC);
      tr.push_back(B | DN);
      return;
    end
    d = 2;
    while (tr.size() < maxlen) begin
      tr.push_back(B);
      if (d > x / 2) begin
        tr.push_back(B | DN);
        return;
      end
      tr.push_back(B | TMP1C);
      r = x;
      while (r >= d && tr.size() < maxlen) begin
        tr.push_back(B | TMP1C | TSEL);
        r -= d;
      end
      tr.push_back(B);
      if (r == 0) begin
        tr.push_back(B);
        tr.push_back(B | RESC);
        tr.push_back(B | DN);
        return;
      end
      tr.push_back(B | DIVC | DSEL);
      d++;
    end
  endfunction

  function automatic int count_bits(input logic [9:0] m);
    int c = 0;
    foreach (tr[i]) if ((tr[i] & m) == m) c++;
    return c;
  endfunction

  task automatic expect_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] act, exp;
    if (chk_en) begin
      act = {dprst, nc, divc, tmp1c, tmp2c, resc, div_sel, tmp1_sel, done, busy};
      exp = q.size() > 0 ? q.pop_front() : 10'h000;
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL outputs @%0t: got %b expected %b", $time, act, exp);
      end
    end
  end

  task automatic run_test(input int x, input bit hold, input bit ds);
    int len;
    n_in = DW'(x);
    start = 1;
    @(posedge clk); #1;
    gen(x, 1 << 30);
    len = tr.size();
    foreach (tr[i]) q.push_back(tr[i]);
    start = hold;
    repeat (len - 1) @(posedge clk);
    #1;
    expect_int($sformatf("res n=%0d", x), int'(res), int'(is_prime(x)));
    start = ds | hold;
    @(posedge clk); #1;
    start = hold;
  endtask

  initial begin
    gen(1, 1 << 30);
    expect_int("len n=1", tr.size(), 5);
    gen(2, 1 << 30);
    expect_int("len n=2", tr.size(), 5);
    expect_int("tmp1c n=2", count_bits(TMP1C), 0);
    gen(7, 1 << 30);
    expect_int("len n=7", tr.size(), 18);
    expect_int("subs n=7", count_bits(TMP1C | TSEL), 5);
    expect_int("prime 7", int'(is_prime(7)), 1);
    expect_int("prime 9", int'(is_prime(9)), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    expect_int("busy after reset", int'(busy), 0);
    run_test(1, 0, 0);
    run_test(2, 0, 1);
    run_test(7, 0, 0);
    expect_int("div after n=7", int'(dv), 4);
    run_test(9, 0, 0);
    run_test(13, 0, 0);
    run_test(17, 1, 0);
    run_test(15, 1, 0);
    run_test(3, 0, 0);
    for (int i = 0; i < 20; i++)
      run_test(int'($urandom_range(0, 300)), i < 19 ? bit'($urandom_range(0, 1)) : 1'b0,
               bit'($urandom_range(0, 1)));
    n_in = 16'd65521;
    start = 1;
    @(posedge clk); #1;
    gen(65521, 40);
    foreach (tr[i]) q.push_back(tr[i]);
    start = 0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1;
    start = 1;
    @(posedge clk); #1;
    q.delete();
    expect_int("busy after mid reset", int'(busy), 0);
    expect_int("enables after mid reset", int'({dprst, nc, divc, tmp1c, tmp2c, resc}), 0);
    @(posedge clk); #1;
    rst = 0;
    start = 0;
    run_test(4, 0, 0);
    run_test(65521 % 300, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prime_ctrl.md
PRIME_CTRL -- requirements
Module: prime_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous reset, active-high (reset rst, synchronous, active-high; clock clk).
REQ-003 SHALL have port: start  input  1  request to test the value presented on the datapath n input.
REQ-004 SHALL have port: n_lt2  input  1  datapath status, n register < 2.
REQ-005 SHALL have port: div_gt_half  input  1  datapath status, div register > tmp2 register (tmp2 = n>>1).
REQ-006 SHALL have port: rem_lt_div  input  1  datapath status, tmp1 register < div register.
REQ-007 SHALL have port: rem_zero  input  1  datapath status, tmp1 register == 0.
REQ-008 SHALL have port: dprst  output  1  datapath clear pulse; restores n/div/tmp1/tmp2 to 0 and res to 1.
REQ-009 SHALL have ports: nc, divc, tmp1c, tmp2c, resc  output  1 each  datapath load enables.
REQ-010 SHALL have port: div_sel  output  1  div source select; 0 = constant 2, 1 = div+1.
REQ-011 SHALL have port: tmp1_sel  output  1  tmp1 source select; 0 = n, 1 = tmp1-div.
REQ-012 SHALL have ports: busy  output  1  test in progress; done  output  1  one-cycle completion pulse (datapath res valid while high).

Function
REQ-013 SHALL implement FSM states IDLE, CLR, LOAD, INIT, CHKDIV, REMINIT, REMLOOP, CHKREM, NOTP, DONE.
REQ-014 IDLE: all outputs 0; start=1 -> CLR; start=0 -> stay.
REQ-015 CLR: dprst=1 -> LOAD.
REQ-016 LOAD: nc=1 -> INIT.
REQ-017 INIT: tmp2c=1, divc=1, div_sel=0; n_lt2=1 -> NOTP, else -> CHKDIV.
REQ-018 CHKDIV: div_gt_half=1 -> DONE (prime), else -> REMINIT.
REQ-019 REMINIT: tmp1c=1, tmp1_sel=0 -> REMLOOP.
REQ-020 REMLOOP: rem_lt_div=0 -> tmp1c=1, tmp1_sel=1, stay; rem_lt_div=1 -> no enables, -> CHKREM.
REQ-021 CHKREM: rem_zero=1 -> NOTP; else divc=1, div_sel=1, -> CHKDIV.
REQ-022 NOTP: resc=1 -> DONE.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy=1.
REQ-025 Enables in REMLOOP/CHKREM SHALL be combinational from state and status (Mealy); all other outputs SHALL decode from state only.
REQ-026 At most one of div_sel/tmp1_sel SHALL be meaningful per cycle; a select SHALL be 0 whenever its enable is 0.
REQ-027 Start asserted in the DONE cycle SHALL be ignored; a new test requires start high in IDLE.
REQ-028 Datapath width SHALL be 16 bits; termination is guaranteed because div increments monotonically to tmp2+1 <= 32768.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE with all outputs 0, including mid-test; the next start SHALL begin a clean test (CLR reinitialises the datapath).
REQ-030 rst SHALL take priority over start and all status inputs.

Structure
REQ-031 State encoding (4-bit) and the datapath width constant (16) SHALL be defined in a shared package used by prime_ctrl and the datapath.
REQ-032 No sub-module is needed; prime_ctrl SHALL be a single FSM with next-state and output-decode blocks.

Verification
REQ-033 n=1, start pulse at edge E -> NOTP visited, done=1 in the cycle after edge E+4, res=0.
REQ-034 n=2, start at edge E -> path INIT, CHKDIV, DONE; done=1 in the cycle after edge E+4, res=1, no tmp1c ever asserted.
REQ-035 n=7 -> REMLOOP subtracts 7->5->3->1 (div=2), then 7->4->1 (div=3), div=4 > 3 -> done with res=1.
REQ-036 n=9 -> div=3 remainder 0 -> NOTP, done with res=0; then n=13 back-to-back -> res=1 (CLR restores res).
REQ-037 rst asserted during REMLOOP of n=65521 -> IDLE next cycle, busy=0, all enables 0; restart with n=4 -> res=0.
REQ-038 start held high throughout a test -> exactly one done per IDLE->CLR entry, busy never drops mid-test.
